// File: rtl/ram_stream_reader_if.sv
// RAM read port plus output stream of ram_stream_reader.
// master = the reader, slave = RAM model / downstream consumer.
interface ram_stream_reader_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output ram_en, ram_addr, out_data, out_valid,
        input  ram_rdata, out_ready
    );

    modport slave (
        input  ram_en, ram_addr, out_data, out_valid,
        output ram_rdata, out_ready
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Sweeps a contiguous RAM address range and streams the words out over valid/ready.
// Optional RAM_STREAM_READER_CHECKSUM_EN adds a running XOR of accepted words.
module ram_stream_reader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    ram_stream_reader_if.master bus
`ifdef RAM_STREAM_READER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    generate
        if (RD_LAT != 1) begin : g_bad_rd_lat
            $error("ram_stream_reader: only RD_LAT=1 is supported");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  issue_rem_q, accept_rem_q;
    logic              inflight_q;
    logic [1:0]        occ_q, occ_d;
    logic [DATA_W-1:0] buf0_q, buf1_q;
    logic              out_valid_q, busy_q, done_q;

    logic              pop, push, room;
    logic [2:0]        load;
    logic              issue_c, start_ok_c, done_c;

    assign pop  = out_valid_q & bus.out_ready;
    assign push = inflight_q;
    // A word accepted this cycle frees its slot for this cycle's issue decision.
    assign load  = {1'b0, occ_q} + 3'(inflight_q) - 3'(pop);
    assign room  = load < 3'd2;
    assign occ_d = occ_q + 2'(push) - 2'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok_c) state_d = S_READ;
            S_READ:  if (issue_c && issue_rem_q == CNT_W'(1)) state_d = S_DRAIN;
            S_DRAIN: if (done_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue_c    = 1'b0;
        start_ok_c = 1'b0;
        done_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                start_ok_c = start && (count != '0);
                done_c     = start && (count == '0);
            end
            S_READ:  issue_c = (issue_rem_q != '0) && room;
            S_DRAIN: done_c  = pop && (accept_rem_q == CNT_W'(1));
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            issue_rem_q  <= '0;
            accept_rem_q <= '0;
            inflight_q   <= 1'b0;
            occ_q        <= 2'd0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            if (start_ok_c) begin
                addr_q       <= base_addr;
                issue_rem_q  <= count;
                accept_rem_q <= count;
            end else begin
                if (issue_c) begin
                    addr_q      <= addr_q + ADDR_W'(1);
                    issue_rem_q <= issue_rem_q - CNT_W'(1);
                end
                if (pop) accept_rem_q <= accept_rem_q - CNT_W'(1);
            end
            inflight_q  <= issue_c;
            occ_q       <= occ_d;
            out_valid_q <= occ_d != 2'd0;
            // Two-entry in-order buffer: buf0 is always the head.
            if (push && pop) begin
                if (occ_q == 2'd2) begin
                    buf0_q <= buf1_q;
                    buf1_q <= bus.ram_rdata;
                end else begin
                    buf0_q <= bus.ram_rdata;
                end
            end else if (pop) begin
                buf0_q <= buf1_q;
            end else if (push) begin
                if (occ_q == 2'd0) buf0_q <= bus.ram_rdata;
                else               buf1_q <= bus.ram_rdata;
            end
            busy_q <= state_d != S_IDLE;
            done_q <= done_c;
        end
    end

    assign bus.ram_en    = issue_c;
    assign bus.ram_addr  = addr_q;
    assign bus.out_data  = buf0_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

`ifdef RAM_STREAM_READER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          csum_q <= '0;
        else if (start_ok_c) csum_q <= '0;
        else if (pop)        csum_q <= csum_q ^ buf0_q;
    end

    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: table of sweeps plus reset, count=0 and checksum sequences.
module tb_ram_stream_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] base_addr;
    logic [4:0] count;
    logic       busy;
    logic       done;
`ifdef RAM_STREAM_READER_CHECKSUM_EN
    logic [7:0] checksum;
    logic [7:0] csum_at_done;
`endif

    ram_stream_reader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    ram_stream_reader #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
`ifdef RAM_STREAM_READER_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .bus       (bus)
    );

    logic [7:0] mem [16];
    int n_checks = 0;
    int n_err    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with one cycle of read latency
    always @(posedge clk) if (bus.ram_en) bus.ram_rdata <= mem[bus.ram_addr];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]  base;
        logic [4:0]  cnt;
        logic [15:0] pat;
        logic [7:0]  first;
        logic [7:0]  last;
        int          done_cyc;
    } vec_t;

    task automatic sweep(input logic [3:0] b, input logic [4:0] cnt, input logic [15:0] pat,
                         input logic [7:0] first, input logic [7:0] last, input int done_cyc);
        int issued = 0, acc = 0, pop = 0, first_v = 0;
        bit fin = 0;
        logic [7:0] got_first = 8'h00, got_last = 8'h00;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; count = cnt; bus.out_ready = 1'b1;
        for (int c = 1; c <= 300 && !fin; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            bus.out_ready = pat[(c - 1) % 16];
            #1;
            pop = (bus.out_valid && bus.out_ready) ? 1 : 0;
            if (bus.ram_en) begin
                check("issue_room", ((issued - acc - pop) < 2) ? 1 : 0, 1);
                check("ram_addr", int'(bus.ram_addr), (b + issued) % 16);
                issued++;
            end
            if (pat == 16'hFFFF && c <= int'(cnt)) check("ram_en_burst", int'(bus.ram_en), 1);
            if (pop != 0) begin
                check("out_data", int'(bus.out_data), int'(mem[(b + acc) % 16]));
                if (acc == 0) begin
                    first_v = c;
                    got_first = bus.out_data;
                end
                got_last = bus.out_data;
                acc++;
            end
            if (done) begin
                fin = 1;
                check("done_busy", int'(busy), 0);
                check("done_count", acc, int'(cnt));
                check("issue_count", issued, int'(cnt));
                if (done_cyc != 0) check("done_cycle", c, done_cyc);
`ifdef RAM_STREAM_READER_CHECKSUM_EN
                csum_at_done = checksum;
`endif
            end else begin
                check("busy", int'(busy), 1);
            end
        end
        if (!fin) check("done_timeout", 0, 1);
        check("first_word", int'(got_first), int'(first));
        check("last_word", int'(got_last), int'(last));
        if (pat == 16'hFFFF) check("first_valid_lat", first_v, 3);
        @(posedge clk); #2;
        check("done_single", int'(done), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_valid", int'(bus.out_valid), 0);
    endtask

    initial begin
        vec_t vecs [6];
        int acc, dones;

        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 8'h11);

        vecs[0] = '{base: 4'd2,  cnt: 5'd4,  pat: 16'hFFFF, first: 8'h22, last: 8'h55, done_cyc: 7};
        vecs[1] = '{base: 4'd14, cnt: 5'd4,  pat: 16'hFFFF, first: 8'hEE, last: 8'h11, done_cyc: 7};
        vecs[2] = '{base: 4'd5,  cnt: 5'd6,  pat: 16'h9A69, first: 8'h55, last: 8'hAA, done_cyc: 0};
        vecs[3] = '{base: 4'd0,  cnt: 5'd16, pat: 16'hFFFF, first: 8'h00, last: 8'hFF, done_cyc: 19};
        vecs[4] = '{base: 4'd9,  cnt: 5'd3,  pat: 16'h5555, first: 8'h99, last: 8'hBB, done_cyc: 0};
        vecs[5] = '{base: 4'd3,  cnt: 5'd5,  pat: 16'h0F0F, first: 8'h33, last: 8'h77, done_cyc: 0};

        rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ram_en", int'(bus.ram_en), 0);
        check("rst_ram_addr", int'(bus.ram_addr), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        @(negedge clk); rst_n = 1'b1;

        for (int v = 0; v < 6; v++)
            sweep(vecs[v].base, vecs[v].cnt, vecs[v].pat, vecs[v].first, vecs[v].last, vecs[v].done_cyc);

        // count=0: immediate done, nothing else moves
        @(posedge clk); #1;
        start = 1'b1; base_addr = 4'd7; count = 5'd0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        check("cnt0_done", int'(done), 1);
        check("cnt0_busy", int'(busy), 0);
        check("cnt0_ram_en", int'(bus.ram_en), 0);
        check("cnt0_valid", int'(bus.out_valid), 0);
        @(posedge clk); #2;
        check("cnt0_done_clear", int'(done), 0);
        check("cnt0_busy2", int'(busy), 0);

        // Reset mid-sweep after two of eight words
        @(posedge clk); #1;
        start = 1'b1; base_addr = 4'd0; count = 5'd8; bus.out_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 20 && acc < 2; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            if (bus.out_valid && bus.out_ready) acc++;
        end
        check("rst_mid_words", acc, 2);
        @(posedge clk); #1;
        check("rst_mid_busy_pre", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_ram_en", int'(bus.ram_en), 0);
        check("rst_mid_ram_addr", int'(bus.ram_addr), 0);
        check("rst_mid_valid", int'(bus.out_valid), 0);
        check("rst_mid_data", int'(bus.out_data), 0);
        check("rst_mid_done", int'(done), 0);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #2;
            if (done || busy || bus.out_valid) dones++;
        end
        check("rst_mid_quiet", dones, 0);
        sweep(4'd0, 5'd1, 16'hFFFF, 8'h00, 8'h00, 4);

`ifdef RAM_STREAM_READER_CHECKSUM_EN
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h04; mem[3] = 8'h08;
        sweep(4'd0, 5'd4, 16'hFFFF, 8'h01, 8'h08, 7);
        check("csum_done", int'(csum_at_done), 8'h0F);
        check("csum_hold", int'(checksum), 8'h0F);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 4'd4; count = 5'd1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        check("csum_clear", int'(checksum), 0);
        repeat (8) @(posedge clk);
        #2;
        check("csum_second", int'(checksum), int'(mem[4]));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
